keccak_block_loader: RTL and testbench

//  Producer side of the Keccak absorb-buffer interface. Packs 64-bit host words into a

---
 rtl/keccak_block_loader.sv | 193 +++++++++++++++++++
 tb/tb_keccak_block_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_block_loader.sv
// Packs 64-bit host words into a 64*LANES-bit Keccak rate block and applies pad10*1 with DSBYTE.
// Optional feature macro KECCAK_LOADER_BLKCNT_EN adds blk_cnt, a per-message acknowledged-block count.
module keccak_block_loader #(
  parameter int unsigned LANES  = 17,
  parameter logic [7:0]  DSBYTE = 8'h06
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_data,
  input  logic                  in_last,
  input  logic [3:0]            in_bytes,
  input  logic                  blk_ack,
  output logic                  buff_full,
  output logic                  first,
  output logic                  last,
  output logic [64*LANES-1:0]   block,
`ifdef KECCAK_LOADER_BLKCNT_EN
  output logic [15:0]           blk_cnt,
`endif
  output logic                  msg_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_PADBLK = 2'd2;
  localparam logic [1:0] S_FULL   = 2'd3;

  localparam int unsigned    LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]  LANE_MAX = LW'(LANES - 1);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] lane_cnt_q, lane_cnt_d;
  logic [63:0]   lanes_q [LANES];
  logic [63:0]   lanes_d [LANES];
  logic          last_q, last_d;
  logic          pad_pend_q, pad_pend_d;
  logic          first_pend_q, first_pend_d;
  logic          msg_done_q, msg_done_d;

  logic          xfer;
  logic [3:0]    n_eff;
  logic [LW-1:0] lane_nxt;
  logic          fin_no_room;

  assign in_ready    = (state_q == S_FILL);
  assign xfer        = in_valid & in_ready;
  assign n_eff       = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign lane_nxt    = lane_cnt_q + 1'b1;
  // A full final word landing in the top lane leaves no byte for padding: a whole pad block follows.
  assign fin_no_room = (n_eff == 4'd8) && (lane_cnt_q == LANE_MAX);

  // Final-word lane: keep the n valid bytes, place the domain byte right after them.
  function automatic logic [63:0] tail_lane(input logic [63:0] d, input logic [3:0] n);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < n) begin
        r[8*b +: 8] = d[8*b +: 8];
      end else if (4'(b) == n) begin
        r[8*b +: 8] = DSBYTE;
      end
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    lanes_d      = lanes_q;
    last_d       = last_q;
    pad_pend_d   = pad_pend_q;
    first_pend_d = first_pend_q;
    msg_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FILL;
      end

      S_FILL: begin
        if (xfer) begin
          if (!in_last) begin
            for (int i = 0; i < int'(LANES); i++) begin
              if (LW'(i) == lane_cnt_q) lanes_d[i] = in_data;
            end
            if (lane_cnt_q == LANE_MAX) begin
              state_d    = S_FULL;
              lane_cnt_d = '0;
              last_d     = 1'b0;
              pad_pend_d = 1'b0;
            end else begin
              lane_cnt_d = lane_nxt;
            end
          end else begin
            for (int i = 0; i < int'(LANES); i++) begin
              if (LW'(i) == lane_cnt_q) begin
                lanes_d[i] = tail_lane(in_data, n_eff);
              end else if (LW'(i) > lane_cnt_q) begin
                lanes_d[i] = ((n_eff == 4'd8) && (LW'(i) == lane_nxt)) ? {56'd0, DSBYTE} : 64'd0;
              end
            end
            if (!fin_no_room) begin
              lanes_d[LANES-1][63:56] = lanes_d[LANES-1][63:56] ^ 8'h80;
            end
            state_d    = S_FULL;
            lane_cnt_d = '0;
            last_d     = !fin_no_room;
            pad_pend_d = fin_no_room;
          end
        end
      end

      S_PADBLK: begin
        for (int i = 0; i < int'(LANES); i++) lanes_d[i] = 64'd0;
        lanes_d[0][7:0]         = DSBYTE;
        lanes_d[LANES-1][63:56] = lanes_d[LANES-1][63:56] ^ 8'h80;
        state_d    = S_FULL;
        last_d     = 1'b1;
        pad_pend_d = 1'b0;
      end

      S_FULL: begin
        if (blk_ack) begin
          if (pad_pend_q) begin
            state_d      = S_PADBLK;
            first_pend_d = 1'b0;
          end else if (last_q) begin
            state_d      = S_IDLE;
            msg_done_d   = 1'b1;
            first_pend_d = 1'b1;
          end else begin
            state_d      = S_FILL;
            first_pend_d = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lane_cnt_q   <= '0;
      last_q       <= 1'b0;
      pad_pend_q   <= 1'b0;
      first_pend_q <= 1'b1;
      msg_done_q   <= 1'b0;
      // NOTE: the lane array is reset because it drives the block output, which must read zero after reset.
      for (int i = 0; i < int'(LANES); i++) lanes_q[i] <= 64'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      last_q       <= last_d;
      pad_pend_q   <= pad_pend_d;
      first_pend_q <= first_pend_d;
      msg_done_q   <= msg_done_d;
      lanes_q      <= lanes_d;
    end
  end

  assign buff_full = (state_q == S_FULL);
  assign first     = first_pend_q & buff_full;
  assign last      = last_q & buff_full;
  assign msg_done  = msg_done_q;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_block
    assign block[64*g +: 64] = lanes_q[g];
  end

`ifdef KECCAK_LOADER_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  // Cleared the cycle after msg_done; saturating so a runaway message cannot wrap the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= 16'd0;
    end else if (msg_done_q) begin
      blk_cnt_q <= 16'd0;
    end else if ((state_q == S_FULL) && blk_ack && (blk_cnt_q != 16'hFFFF)) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_keccak_block_loader.sv
// Randomized scoreboard bench for keccak_block_loader: a byte-level SHA-3 pad10*1 model predicts
// every presented block; a negedge monitor compares blocks, first/last flags, stability and msg_done.
module tb_keccak_block_loader;

  localparam int unsigned LANES = 17;
  localparam logic [7:0]  DS    = 8'h06;
  localparam int          RATE  = 8 * LANES;

  typedef logic [7:0] u8;
  typedef struct {
    logic [64*LANES-1:0] data;
    bit                  first;
    bit                  last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid, in_ready, in_last, blk_ack;
  logic [63:0]         in_data;
  logic [3:0]          in_bytes;
  logic                buff_full, dut_first, dut_last, msg_done;
  logic [64*LANES-1:0] block;
`ifdef KECCAK_LOADER_BLKCNT_EN
  logic [15:0]         blk_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   long_ack = 1'b0;
  bit   spurious_en = 1'b0;

  keccak_block_loader #(.LANES(LANES), .DSBYTE(DS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_ack   (blk_ack),
    .buff_full (buff_full),
    .first     (dut_first),
    .last      (dut_last),
    .block     (block),
`ifdef KECCAK_LOADER_BLKCNT_EN
    .blk_cnt   (blk_cnt),
`endif
    .msg_done  (msg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic stop_run(input string why);
    checks++;
    failures++;
    $display("FAIL %s", why);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " in_ready"},  {63'd0, in_ready},  64'd0);
    check({tag, " buff_full"}, {63'd0, buff_full}, 64'd0);
    check({tag, " first"},     {63'd0, dut_first}, 64'd0);
    check({tag, " last"},      {63'd0, dut_last},  64'd0);
    check({tag, " msg_done"},  {63'd0, msg_done},  64'd0);
    for (int i = 0; i < int'(LANES); i++)
      check($sformatf("%s lane%0d", tag, i), block[64*i +: 64], 64'd0);
  endtask

  // Present one word, hold it until accepted; random idle gaps carry junk that must be ignored.
  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
    int budget;
    while ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bytes = nb;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 600) stop_run("in_ready timeout");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_last  = 1'($urandom_range(0, 1));
    in_bytes = 4'($urandom_range(0, 15));
  endtask

  // Model: append DS, zero-fill to a block boundary, set the top bit of the final byte.
  task automatic run_msg(input u8 msg[$], input bit zero_tail, input bit big_nb);
    int   len, nw, n, nblk;
    u8    pad[$];
    exp_t e;
    logic [63:0] w;
    logic [3:0]  nb;
    len = msg.size();
    if (len == 0) begin
      nw = 1; n = 0;
    end else if (zero_tail && (len % 8 == 0)) begin
      nw = len / 8 + 1; n = 0;
    end else begin
      nw = (len + 7) / 8; n = len - 8 * (nw - 1);
    end
    pad = msg;
    pad.push_back(DS);
    while (pad.size() % RATE != 0) pad.push_back(8'h00);
    pad[pad.size()-1] = pad[pad.size()-1] ^ 8'h80;
    nblk = pad.size() / RATE;
    for (int k = 0; k < nblk; k++) begin
      for (int b = 0; b < RATE; b++) e.data[8*b +: 8] = pad[k*RATE + b];
      e.first = (k == 0);
      e.last  = (k == nblk - 1);
      exp_q.push_back(e);
    end
    for (int wi = 0; wi < nw; wi++) begin
      for (int b = 0; b < 8; b++)
        w[8*b +: 8] = (8*wi + b < len) ? msg[8*wi + b] : 8'($urandom_range(0, 255));
      if (wi == nw - 1)
        nb = (n == 8 && big_nb) ? 4'(8 + $urandom_range(1, 7)) : 4'(n);
      else
        nb = 4'($urandom_range(0, 15));
      send_word(w, wi == nw - 1, nb);
    end
  endtask

  task automatic rand_msg(input int len, output u8 m[$]);
    m = {};
    for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 || buff_full) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 800) stop_run("drain timeout");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Acknowledge each presented block after a random (or long) delay; stray acks outside FULL.
  initial begin : acker
    int ack_wait;
    blk_ack  = 1'b0;
    ack_wait = -1;
    forever begin
      @(posedge clk); #1;
      blk_ack = 1'b0;
      if (!rst_n) begin
        ack_wait = -1;
      end else if (buff_full) begin
        if (ack_wait < 0) ack_wait = long_ack ? 10 : int'($urandom_range(0, 4));
        if (ack_wait == 0) begin
          blk_ack  = 1'b1;
          ack_wait = -1;
        end else begin
          ack_wait--;
        end
      end else begin
        ack_wait = -1;
        if (spurious_en && $urandom_range(0, 7) == 0) blk_ack = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t cur;
    bit   seen = 1'b0;
    bit   done_next = 1'b0;
    int   blk_idx = 0;
`ifdef KECCAK_LOADER_BLKCNT_EN
    int   cnt_exp = 0;
`endif
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen      = 1'b0;
        done_next = 1'b0;
`ifdef KECCAK_LOADER_BLKCNT_EN
        cnt_exp   = 0;
`endif
      end else begin
        if (msg_done || done_next)
          check("msg_done pulse", {63'd0, msg_done}, {63'd0, done_next});
`ifdef KECCAK_LOADER_BLKCNT_EN
        check("blk_cnt", {48'd0, blk_cnt}, 64'(cnt_exp));
        if (msg_done) cnt_exp = 0;
        else if (buff_full && blk_ack && cnt_exp < 16'hFFFF) cnt_exp++;
`endif
        done_next = 1'b0;
        if (buff_full) begin
          if (!seen) begin
            if (exp_q.size() == 0) begin
              check("unexpected block", 64'd1, 64'd0);
              cur.data = block; cur.first = 1'b0; cur.last = 1'b0;
            end else begin
              cur = exp_q.pop_front();
              for (int i = 0; i < int'(LANES); i++)
                check($sformatf("blk%0d lane%0d", blk_idx, i), block[64*i +: 64], cur.data[64*i +: 64]);
              check($sformatf("blk%0d first", blk_idx), {63'd0, dut_first}, {63'd0, cur.first});
              check($sformatf("blk%0d last", blk_idx), {63'd0, dut_last}, {63'd0, cur.last});
            end
            blk_idx++;
            seen = 1'b1;
          end else begin
            check("block stable", {63'd0, (block === cur.data)}, 64'd1);
          end
          if (blk_ack) done_next = cur.last;
        end else begin
          seen = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    stop_run("watchdog timeout");
  end

  initial begin : stim
    u8 m[$];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty message.
    m = {};
    run_msg(m, 1'b0, 1'b0);
    // 3-byte message AA BB CC.
    m = {8'hAA, 8'hBB, 8'hCC};
    run_msg(m, 1'b0, 1'b0);
    // Exactly one rate of data: full block then a pure pad block.
    rand_msg(RATE, m);
    run_msg(m, 1'b0, 1'b0);
    // One byte short of a rate: DS and 0x80 share the top byte.
    rand_msg(RATE - 1, m);
    run_msg(m, 1'b0, 1'b0);
    // Full final word in lane LANES-2: DS lands in byte 0 of the top lane.
    rand_msg(RATE - 8, m);
    run_msg(m, 1'b0, 1'b0);
    // Oversized in_bytes on a full final word.
    rand_msg(16, m);
    run_msg(m, 1'b0, 1'b1);
    // Word-aligned message closed by an empty final word.
    rand_msg(8, m);
    run_msg(m, 1'b1, 1'b0);
    drain();

    // 40 words with slow acknowledges; host keeps in_valid asserted while blocks are held.
    long_ack = 1'b1;
    rand_msg(320, m);
    run_msg(m, 1'b0, 1'b0);
    drain();
    long_ack = 1'b0;

    // Reset in the middle of filling (lane 5): partial block discarded.
    spurious_en = 1'b1;
    for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midfill reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized messages with stray acks.
    for (int t = 0; t < 12; t++) begin
      rand_msg(int'($urandom_range(0, 420)), m);
      run_msg(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
